// File: rtl/decode_alu_ctrl.sv
// RV32I decode stage: instruction -> ALU control bundle, behind a
// two-entry (main + skid) output buffer with synchronous flush.
package decode_alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_DISABLE       = 4'd0,
    ALU_ADD           = 4'd1,
    ALU_SUB           = 4'd2,
    ALU_SLL           = 4'd3,
    ALU_SRL           = 4'd4,
    ALU_SRA           = 4'd5,
    ALU_XOR           = 4'd6,
    ALU_OR            = 4'd7,
    ALU_AND           = 4'd8,
    ALU_ADD_SIGN_FLIP = 4'd9
  } e_alu_function;

  typedef struct packed {
    e_alu_function fn;
    logic [1:0]    op1_sel;
    logic [1:0]    op2_sel;
    logic [31:0]   imm;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          rd_we;
    logic [31:0]   pc;
    logic          illegal;
  } dec_t;

endpackage

module decode_alu_ctrl
  import decode_alu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output e_alu_function out_alu_function,
  output logic [1:0]    out_op1_sel,
  output logic [1:0]    out_op2_sel,
  output logic [31:0]   out_imm,
  output logic [4:0]    out_rs1,
  output logic [4:0]    out_rs2,
  output logic [4:0]    out_rd,
  output logic          out_rd_we,
  output logic [31:0]   out_pc,
  output logic          out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;
  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  // instruction fields and immediates
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opc   = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

  e_alu_function w_fn;
  logic [1:0]    w_op1, w_op2;
  logic [31:0]   w_imm;
  logic          w_wr, w_legal;
  dec_t          w_dec, w_rst;

  // opcode/funct decode; anything left at ALU_DISABLE is illegal
  always_comb begin
    w_fn  = ALU_DISABLE;
    w_op1 = OP1_RS1;
    w_op2 = OP2_RS2;
    w_imm = '0;
    w_wr  = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_wr = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'b000:  w_fn = ALU_ADD;
            3'b001:  w_fn = ALU_SLL;
            3'b100:  w_fn = ALU_XOR;
            3'b101:  w_fn = ALU_SRL;
            3'b110:  w_fn = ALU_OR;
            3'b111:  w_fn = ALU_AND;
            default: w_fn = ALU_DISABLE;
          endcase
        end else if (w_f7 == F7_ALT) begin
          case (w_f3)
            3'b000:  w_fn = ALU_SUB;
            3'b101:  w_fn = ALU_SRA;
            default: w_fn = ALU_DISABLE;
          endcase
        end
      end
      OPC_OPIMM: begin
        w_wr  = 1'b1;
        w_op2 = OP2_IMM;
        w_imm = w_imm_i;
        case (w_f3)
          3'b000: w_fn = ALU_ADD;
          3'b001: if (w_f7 == F7_BASE) w_fn = ALU_SLL;
          3'b100: w_fn = ALU_XOR;
          3'b101: begin
            if (w_f7 == F7_BASE) w_fn = ALU_SRL;
            else if (w_f7 == F7_ALT) begin
              // drop the funct7 bits so the ALU sees a bare shift amount
              w_fn  = ALU_SRA;
              w_imm = {27'b0, in_instr[24:20]};
            end
          end
          3'b110:  w_fn = ALU_OR;
          3'b111:  w_fn = ALU_AND;
          default: w_fn = ALU_DISABLE;
        endcase
      end
      OPC_LUI: begin
        w_fn = ALU_ADD; w_op1 = OP1_ZERO; w_op2 = OP2_IMM; w_imm = w_imm_u; w_wr = 1'b1;
      end
      OPC_AUIPC: begin
        w_fn = ALU_ADD; w_op1 = OP1_PC; w_op2 = OP2_IMM; w_imm = w_imm_u; w_wr = 1'b1;
      end
      OPC_JAL: begin
        w_fn = ALU_ADD; w_op1 = OP1_PC; w_op2 = OP2_FOUR; w_imm = w_imm_j; w_wr = 1'b1;
      end
      OPC_JALR: begin
        w_fn = ALU_ADD; w_op1 = OP1_PC; w_op2 = OP2_FOUR; w_imm = w_imm_i; w_wr = 1'b1;
      end
      OPC_LOAD: begin
        w_fn = ALU_ADD; w_op2 = OP2_IMM; w_imm = w_imm_i; w_wr = 1'b1;
      end
      OPC_STORE: begin
        w_fn = ALU_ADD; w_op2 = OP2_IMM; w_imm = w_imm_s;
      end
      OPC_BRANCH: begin
        w_fn = ALU_SUB; w_imm = w_imm_b;
      end
      default: w_fn = ALU_DISABLE;
    endcase
  end

  assign w_legal = (w_fn != ALU_DISABLE);

  // assemble the bundle; illegal encodings collapse to a neutral bundle
  always_comb begin
    w_dec         = '0;
    w_dec.fn      = w_fn;
    w_dec.op1_sel = w_legal ? w_op1 : 2'd0;
    w_dec.op2_sel = w_legal ? w_op2 : 2'd0;
    w_dec.imm     = w_legal ? w_imm : 32'd0;
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.rd      = in_instr[11:7];
    w_dec.rd_we   = w_legal & w_wr & (in_instr[11:7] != 5'd0);
    w_dec.pc      = in_pc;
    w_dec.illegal = ~w_legal;
  end

  // constant payload loaded while in reset
  always_comb begin
    w_rst    = '0;
    w_rst.fn = ALU_DISABLE;
    w_rst.pc = RESET_PC;
  end

  // buffer state
  dec_t r_main, r_skid;
  logic r_main_vld, r_skid_vld;
  logic w_accept, w_main_free;

  assign in_ready    = ~r_skid_vld;
  assign w_accept    = in_valid & ~r_skid_vld;
  assign w_main_free = ~r_main_vld | out_ready;

  // occupancy: flush wins, skid refills main first, new decode fills main when free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      r_main_vld <= r_skid_vld | w_accept;
      r_skid_vld <= 1'b0;
    end else if (w_accept) begin
      r_skid_vld <= 1'b1;
    end
  end

  // payload moves; main only changes when free so stalled outputs stay put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= w_rst;
      r_skid <= w_rst;
    end else if (!flush) begin
      if (w_main_free) begin
        if (r_skid_vld)    r_main <= r_skid;
        else if (w_accept) r_main <= w_dec;
      end else if (w_accept) begin
        r_skid <= w_dec;
      end
    end
  end

  assign out_valid        = r_main_vld;
  assign out_alu_function = r_main.fn;
  assign out_op1_sel      = r_main.op1_sel;
  assign out_op2_sel      = r_main.op2_sel;
  assign out_imm          = r_main.imm;
  assign out_rs1          = r_main.rs1;
  assign out_rs2          = r_main.rs2;
  assign out_rd           = r_main.rd;
  assign out_rd_we        = r_main.rd_we;
  assign out_pc           = r_main.pc;
  assign out_illegal      = r_main.illegal;

endmodule

// File: doc/decode_alu_ctrl.md
# decode_alu_ctrl

- Decode stage of the RV32I core: turns a fetched instruction into ALU control for the execute stage.
- Produces the `e_alu_function` selection, operand-source selects, a sign-extended immediate, and register indices.
- Sits between fetch and execute, with valid/ready handshakes on both sides.
- A two-entry skid buffer gives full throughput with a registered output, plus a synchronous flush for branch redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value the output register holds while reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous flush; drops all buffered entries.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: decoder can accept.
- `in_instr` in 32: raw instruction.
- `in_pc` in 32: PC of `in_instr`.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_alu_function` out `e_alu_function`: ALU operation.
- `out_op1_sel` out 2: 0=rs1, 1=pc, 2=zero.
- `out_op2_sel` out 2: 0=rs2, 1=imm, 2=constant 4.
- `out_imm` out 32: sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each: register indices.
- `out_rd_we` out 1: destination write enable.
- `out_pc` out 32: PC passthrough.
- `out_illegal` out 1: unsupported encoding.

## Operation
Decode, by opcode:
- OP (0110011), funct7=0000000:
  - funct3 000 → ADD, 001 → SLL, 100 → XOR, 101 → SRL, 110 → OR, 111 → AND.
  - op1=rs1, op2=rs2, rd_we=1.
- OP, funct7=0100000: funct3 000 → SUB, 101 → SRA.
- OP-IMM (0010011):
  - Same funct3 map, op2=imm (I-type).
  - SLLI/SRLI need imm[11:5]=0000000.
  - SRAI needs imm[11:5]=0100000; `out_imm` = {27'b0, shamt}.
- LUI → ADD, op1=zero, op2=imm (U-type).
- AUIPC → ADD, op1=pc, op2=imm (U-type).
- JAL / JALR → ADD, op1=pc, op2=4, rd_we=1; imm is J-type / I-type.
- LOAD → ADD, op1=rs1, op2=imm (I-type), rd_we=1.
- STORE → ADD, op1=rs1, op2=imm (S-type), rd_we=0.
- BRANCH → SUB, op1=rs1, op2=rs2, imm B-type, rd_we=0.
- Illegal: SLT/SLTU/SLTI/SLTIU, any other funct7 (including M-extension), any other opcode.
  - Output: ALU_DISABLE, rd_we=0, illegal=1, imm=0, selects 0.
  - `ALU_ADD_SIGN_FLIP` is never emitted.
- `out_rd_we` is forced 0 when rd=x0.

Buffering:
- Main output register plus one skid entry.
- `in_ready` = skid entry empty; it is registered, not combinational from `out_ready`.
- Input accepted when in_valid & in_ready; the decode result goes into the main register if it is free or draining this cycle, otherwise into skid.
- Main register empty or draining with skid full: skid moves to main.
- Output fields stay stable while out_valid & !out_ready.

Flush:
- `flush`=1 clears both entries' valid at the edge.
- An input presented in the flush cycle is dropped.
- Flush has priority over simultaneous accept and drain.

Reset (`rst_n`=0, asynchronous):
- out_valid=0, in_ready=1, both entries invalid.
- Payload outputs: out_alu_function=ALU_DISABLE, out_pc=`RESET_PC`, all others 0.

## Timing
- Latency: instruction accepted at edge N shows on outputs after edge N (one cycle).
- Throughput: one instruction per cycle while out_ready=1.
- out_ready low for k cycles:
  - At most one further instruction is taken into skid.
  - in_ready drops after the edge that filled skid.
- Drain from full: out_ready=1 for one edge → main loads skid, in_ready=1 next cycle; empty after two drain edges with no new input.
- Simultaneous accept+drain with skid empty: new decode lands in main, no bubble.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronous); the first accept is possible on the first edge after deassertion.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

## Test plan
- Stream ADD x3,x1,x2 (0x002081B3), then SUB (0x402081B3), then SRAI x5,x6,3 (0x40335293), out_ready=1:
  - ADD: fn=ADD, op1=rs1, op2=rs2, rs1=1, rs2=2, rd=3, rd_we=1.
  - SUB: fn=SUB.
  - SRAI: fn=SRA, imm=3, op2=imm.
  - One per cycle, latency 1.
- LUI x1,0x12345 (0x123450B7):
  - imm=0x12345000, op1=zero, fn=ADD.
- JAL x1,-4 (0xFFDFF0EF), pc=0x100:
  - imm=0xFFFFFFFC, op1=pc, op2=4, out_pc=0x100.
- SLT (0x0020A1B3), MUL (0x022081B3), opcode 0x7F:
  - ALU_DISABLE, illegal=1, rd_we=0.
- Hold out_ready=0 with in_valid=1 for 4 cycles:
  - Two instructions are buffered; in_ready=0 after the second accept.
  - Release out_ready: both emerge in order, no loss or duplication.
- Skid full, assert flush with in_valid=1:
  - out_valid=0 and in_ready=1 next cycle; flushed and presented instructions never appear.
- Assert rst_n=0 asynchronously mid-stream:
  - out_valid falls before the next edge.
  - Restart at the first edge after release.
